// File: rtl/v3_pg_stage_if.sv
// Handshake and data bundle between an operand source, the v3_pg_stage front end
// and the downstream prefix tree.
interface v3_pg_stage_if #(
  parameter int WIDTH = 16
);
  localparam int NGRP = (WIDTH + 3) / 3;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH:0]    g_out;
  logic [WIDTH:0]    p_out;
  logic [NGRP-1:0]   grp_g;
  logic [NGRP-1:0]   grp_p;

  // master = operand source plus downstream consumer; slave = the stage itself
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, g_out, p_out, grp_g, grp_p
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, g_out, p_out, grp_g, grp_p
  );
endinterface

// File: rtl/v3_pg_stage.sv
// Registered bitwise G/P front end with first-level valency-3 group terms and a
// 2-entry skid buffer. Optional counters are enabled with macro V3_PG_PERF_EN.
module v3_pg_stage #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  v3_pg_stage_if.slave      pg
`ifdef V3_PG_PERF_EN
  ,
  output logic [31:0]       xfer_count,
  output logic [31:0]       stall_count
`endif
);
  localparam int NGRP = (WIDTH + 3) / 3;
  localparam int NPAD = 3 * NGRP;

  typedef struct packed {
    logic [WIDTH:0]  g;
    logic [WIDTH:0]  p;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] gp;
  } pgSet_t;

  logic [NPAD-1:0] gPad;
  logic [NPAD-1:0] pPad;
  logic [NGRP-1:0] grpG;
  logic [NGRP-1:0] grpP;
  pgSet_t          newSet;

  // Carry-in occupies position 0 as a pure generate term.
  assign gPad[0] = pg.cin;
  assign pPad[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign gPad[gi+1] = pg.a[gi] & pg.b[gi];
      assign pPad[gi+1] = pg.a[gi] ^ pg.b[gi];
    end
    // Positions beyond the vector are transparent so the top group stays exact.
    for (gi = WIDTH + 1; gi < NPAD; gi++) begin : g_pad
      assign gPad[gi] = 1'b0;
      assign pPad[gi] = 1'b1;
    end
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      assign grpG[gi] = gPad[3*gi+2] | (pPad[3*gi+2] & (gPad[3*gi+1] | (pPad[3*gi+1] & gPad[3*gi])));
      assign grpP[gi] = pPad[3*gi+2] & pPad[3*gi+1] & pPad[3*gi];
    end
  endgenerate

  assign newSet.g  = gPad[WIDTH:0];
  assign newSet.p  = pPad[WIDTH:0];
  assign newSet.gg = grpG;
  assign newSet.gp = grpP;

  pgSet_t orSet, orSetNext;
  pgSet_t srSet, srSetNext;
  logic   orValid, orValidNext;
  logic   srValid, srValidNext;
  logic   inReadyReg;
  logic   inAccept;
  logic   outAccept;

  assign inAccept  = pg.in_valid & pg.in_ready;
  assign outAccept = orValid & pg.out_ready;

  always_comb begin
    orSetNext   = orSet;
    srSetNext   = srSet;
    orValidNext = orValid;
    srValidNext = srValid;
    if (outAccept || !orValid) begin
      // Output register is free this cycle: refill from skid first, then input.
      if (srValid) begin
        orSetNext   = srSet;
        orValidNext = 1'b1;
        srValidNext = 1'b0;
      end else if (inAccept) begin
        orSetNext   = newSet;
        orValidNext = 1'b1;
      end else begin
        orValidNext = 1'b0;
      end
    end else if (inAccept) begin
      srSetNext   = newSet;
      srValidNext = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      orSet      <= '0;
      srSet      <= '0;
      orValid    <= 1'b0;
      srValid    <= 1'b0;
      inReadyReg <= 1'b1;
    end else begin
      orSet      <= orSetNext;
      srSet      <= srSetNext;
      orValid    <= orValidNext;
      srValid    <= srValidNext;
      inReadyReg <= ~srValidNext;
    end
  end

  // Ready depends only on skid occupancy and reset, never on out_ready.
  assign pg.in_ready  = inReadyReg & ~reset;
  assign pg.out_valid = orValid;
  assign pg.g_out     = orSet.g;
  assign pg.p_out     = orSet.p;
  assign pg.grp_g     = orSet.gg;
  assign pg.grp_p     = orSet.gp;

`ifdef V3_PG_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      if (outAccept)
        xfer_count <= xfer_count + 32'd1;
      if (orValid && !pg.out_ready)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_v3_pg_stage.sv
// Self-checking bench for v3_pg_stage: directed scenarios plus random traffic
// scored against an occupancy/ordering queue and an arithmetic G/P model.
module tb_v3_pg_stage;
  localparam int W  = 16;
  localparam int NG = (W + 3) / 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  v3_pg_stage_if #(.WIDTH(W)) pg ();

`ifdef V3_PG_PERF_EN
  logic [31:0] xfer_count;
  logic [31:0] stall_count;
`endif

  v3_pg_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .pg    (pg)
`ifdef V3_PG_PERF_EN
    ,
    .xfer_count  (xfer_count),
    .stall_count (stall_count)
`endif
  );

  typedef struct packed {
    logic [W:0]    g;
    logic [W:0]    p;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   xferExp  = 0;
  int   stallExp = 0;
  int   txn      = 0;

  // Each position is the sum a+b in {0,1,2}; a group carries out of three
  // positions when its weighted sum reaches 8 and propagates when it is exactly 7.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    int   v [0:3*NG-1];
    int   total;
    for (int i = 0; i < 3 * NG; i++) v[i] = 1;
    v[0] = c ? 2 : 0;
    for (int i = 0; i < W; i++) v[i+1] = int'(a[i]) + int'(b[i]);
    for (int i = 0; i <= W; i++) begin
      e.g[i] = (v[i] == 2);
      e.p[i] = (v[i] == 1);
    end
    for (int k = 0; k < NG; k++) begin
      total   = v[3*k] + 2 * v[3*k+1] + 4 * v[3*k+2];
      e.gg[k] = (total >= 8);
      e.gp[k] = (total == 7);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit   inX, outX, stall, rs;
    exp_t cur;
    inX   = (pg.in_valid === 1'b1) && (pg.in_ready === 1'b1);
    outX  = (pg.out_valid === 1'b1) && (pg.out_ready === 1'b1);
    stall = (pg.out_valid === 1'b1) && (pg.out_ready === 1'b0);
    rs    = reset;
    cur   = model(pg.a, pg.b, pg.cin);
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      xferExp  = 0;
      stallExp = 0;
    end else begin
      if (outX) begin
        txn++;
        $display("txn %0d: out g=%h p=%h gg=%h gp=%h", txn, pg.g_out, pg.p_out, pg.grp_g, pg.grp_p);
        xferExp++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (stall) stallExp++;
      if (inX) q.push_back(cur);
    end
    chk("out_valid", 64'(pg.out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(pg.in_ready), 64'(!reset && q.size() < 2));
    if (q.size() > 0) begin
      chk("g_out", 64'(pg.g_out), 64'(q[0].g));
      chk("p_out", 64'(pg.p_out), 64'(q[0].p));
      chk("grp_g", 64'(pg.grp_g), 64'(q[0].gg));
      chk("grp_p", 64'(pg.grp_p), 64'(q[0].gp));
    end
`ifdef V3_PG_PERF_EN
    chk("xfer_count", 64'(xfer_count), 64'(xferExp));
    chk("stall_count", 64'(stall_count), 64'(stallExp));
`endif
  endtask

  // Present one set and hold it until accepted, bounded.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bit acc;
    int n;
    pg.a = a; pg.b = b; pg.cin = c; pg.in_valid = 1'b1;
    n = 0;
    do begin
      acc = (pg.in_ready === 1'b1);
      cycle();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    pg.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend;
    bit acc;
    reset = 1'b1;
    pg.in_valid = 1'b0; pg.out_ready = 1'b0;
    pg.a = '0; pg.b = '0; pg.cin = 1'b0;

    // Reset state
    cycle();
    cycle();
    chk("rst_g_out", 64'(pg.g_out), 64'd0);
    chk("rst_p_out", 64'(pg.p_out), 64'd0);
    chk("rst_grp_g", 64'(pg.grp_g), 64'd0);
    chk("rst_grp_p", 64'(pg.grp_p), 64'd0);
    chk("rst_in_ready", 64'(pg.in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(pg.in_ready), 64'd1);

    // Single transfer
    pg.out_ready = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0);
    chk("t1_out_valid", 64'(pg.out_valid), 64'd1);
    chk("t1_g_out", 64'(pg.g_out), 64'h00002);
    chk("t1_p_out", 64'(pg.p_out), 64'h001FC);
    chk("t1_grp_g0", 64'(pg.grp_g[0]), 64'd1);
    chk("t1_grp_p0", 64'(pg.grp_p[0]), 64'd0);
    cycle();

    // Carry-in and padding
    send(16'hFFFF, 16'h0000, 1'b1);
    chk("t2_g_out", 64'(pg.g_out), 64'h00001);
    chk("t2_p_out", 64'(pg.p_out), 64'h1FFFE);
    chk("t2_grp_g0", 64'(pg.grp_g[0]), 64'd1);
    chk("t2_grp_p5", 64'(pg.grp_p[5]), 64'd1);
    chk("t2_grp_g5", 64'(pg.grp_g[5]), 64'd0);
    cycle();

    // Back-pressure: two accepted, third held, then drain in order
    pg.out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b0);
    send(16'hA5A5, 16'h0F0F, 1'b1);
    chk("bp_in_ready_full", 64'(pg.in_ready), 64'd0);
    pg.a = 16'hBEEF; pg.b = 16'h1111; pg.cin = 1'b1; pg.in_valid = 1'b1;
    cycle();
    cycle();
    chk("bp_still_full", 64'(pg.in_ready), 64'd0);
    pg.out_ready = 1'b1;
    send(16'hBEEF, 16'h1111, 1'b1);
    cycle();
    chk("bp_drained", 64'(pg.out_valid), 64'd0);

    // Streaming at full rate
    pg.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pg.a = W'($urandom); pg.b = W'($urandom); pg.cin = 1'($urandom);
      pg.in_valid = 1'b1;
      cycle();
    end
    pg.in_valid = 1'b0;
    cycle();

    // Random handshake traffic; data held while a set is pending
    pend = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pend) begin
        pg.in_valid = ($urandom_range(0, 3) != 0);
        pg.a = W'($urandom); pg.b = W'($urandom); pg.cin = 1'($urandom);
      end
      pg.out_ready = ($urandom_range(0, 2) != 0);
      acc = pg.in_valid && (pg.in_ready === 1'b1);
      cycle();
      pend = pg.in_valid && !acc;
    end
    pg.in_valid = 1'b0;
    pg.out_ready = 1'b1;
    cycle(); cycle(); cycle();

    // Reset while FULL discards both sets
    pg.out_ready = 1'b0;
    send(16'h0F0F, 16'h00F0, 1'b0);
    send(16'h7777, 16'h8888, 1'b1);
    reset = 1'b1;
    cycle();
    chk("midrst_out_valid", 64'(pg.out_valid), 64'd0);
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(pg.in_ready), 64'd1);
    pg.out_ready = 1'b1;
    cycle(); cycle(); cycle();

`ifdef V3_PG_PERF_EN
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("perf_xfer_rst", 64'(xfer_count), 64'd0);
    chk("perf_stall_rst", 64'(stall_count), 64'd0);
    pg.out_ready = 1'b1;
    send(W'($urandom), W'($urandom), 1'($urandom));
    pg.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    pg.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pg.a = W'($urandom); pg.b = W'($urandom); pg.cin = 1'($urandom);
      pg.in_valid = 1'b1;
      cycle();
    end
    pg.in_valid = 1'b0;
    cycle(); cycle();
    chk("perf_xfer_10", 64'(xfer_count), 64'd10);
    chk("perf_stall_4", 64'(stall_count), 64'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/v3_pg_stage.md
Name: v3_pg_stage

Overview:
- Registered bitwise generate/propagate front end for the valency-3 prefix adder tree.
- Accepts operands A, B and carry-in over a valid/ready handshake.
- Produces the bitwise G/P vectors, with carry-in folded in as position 0, plus the first-level valency-3 group G/P terms.
- Feeds the gray/black cell tree directly; a 2-entry skid buffer keeps throughput at one operand set per cycle under back-pressure.

Parameters:
- WIDTH, 16, operand width in bits (>= 2).
- NGRP, derived, ceil((WIDTH+1)/3), number of valency-3 groups; not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  stage can accept an operand set
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  output set present
- out_ready  input  1  downstream tree accepts
- g_out  output  WIDTH+1  bitwise generate; bit0 = cin, bit i+1 = a[i] & b[i]
- p_out  output  WIDTH+1  bitwise propagate; bit0 = 0, bit i+1 = a[i] ^ b[i]
- grp_g  output  NGRP  group generate G(3k+2:3k)
- grp_p  output  NGRP  group propagate P(3k+2:3k)

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: out_valid=0; g_out, p_out, grp_g, grp_p all 0; skid entry empty. in_ready=0 while reset is high and 1 on the first cycle after reset deasserts.
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Latency: an accepted set appears on the outputs the next cycle when the output register is empty or draining. Throughput is 1 set/cycle while out_ready is held high.
- Storage: output register (OR) plus skid register (SR). in_ready = ~SR_valid & ~reset, driven from a register, with no combinational path from out_ready.
- Buffer state transitions:
  - EMPTY -> ONE on input accept.
  - ONE -> EMPTY on output accept with no input.
  - ONE -> ONE on simultaneous input and output accept (OR reloads).
  - ONE -> FULL on input accept while out_ready=0 (new set goes to SR).
  - FULL -> ONE on output accept (SR moves to OR; in_ready rises the next cycle).
  - No input is accepted in FULL.
- Stall stability: while out_valid=1 and out_ready=0, all outputs hold stable.
- Ordering: strict FIFO; no set is dropped or duplicated.
- Arithmetic: G/P computed combinationally from a, b, cin before registering. Both OR and SR hold the full WIDTH+1 vectors plus group terms.
- Group k covers indices j=3k, j+1, j+2 of the WIDTH+1 vectors:
  - grp_g[k] = g[j+2] | p[j+2] & (g[j+1] | p[j+1] & g[j]).
  - grp_p[k] = p[j+2] & p[j+1] & p[j].
  - Indices >= WIDTH+1 are padded with g=0, p=1.
- Reset mid-operation: any buffered sets are discarded. out_valid drops to 0 the cycle after reset is sampled high.
- in_valid while in_ready=0 is ignored; the source must hold its data.

Optional Feature:
- Macro: V3_PG_PERF_EN.
- Defined: adds 32-bit output ports xfer_count and stall_count.
  - xfer_count increments on each output transfer.
  - stall_count increments on each cycle with out_valid & ~out_ready.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: ports and counters are absent; datapath and handshake timing are identical.

Test Plan:
- Reset then single transfer, WIDTH=16: a=0x00FF, b=0x0001, cin=0 -> next cycle out_valid=1, g_out=0x00002, p_out=0x001FC, grp_g[0]=1, grp_p[0]=0.
- Carry-in and padding: a=0xFFFF, b=0x0000, cin=1 -> g_out=0x00001, p_out=0x1FFFE, grp_g[0]=1, grp_p[5]=1 (index 17 padded), grp_g[5]=0.
- Back-pressure: out_ready=0, present 3 sets back-to-back -> sets 1 and 2 accepted, in_ready=0 from the cycle after set 2, set 3 held. Then out_ready=1 -> sets 1, 2, 3 emerge in order on consecutive cycles.
- Streaming: in_valid=1, out_ready=1 for 100 random sets -> one output per cycle after 1-cycle latency; every output matches the reference model.
- Reset mid-operation: FULL state, assert reset 1 cycle -> out_valid=0 next cycle, in_ready=1 after deassert, no stale set emitted.
- V3_PG_PERF_EN: 10 transfers with 4 stall cycles -> xfer_count=10, stall_count=4; both 0 after reset.
